// File: rtl/branch_resolver_pkg.sv
// Shared types for the commit-side branch resolver: address/index widths,
// flush FSM encodings and the predictor-feedback entry layout.
package branch_resolver_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned PRED_IDX_LO = 2;
  localparam int unsigned PRED_IDX_W  = 8;
  localparam int unsigned STAT_W      = 32;

  typedef enum logic [1:0] {
    FLUSH_IDLE     = 2'd0,
    FLUSH_CLEAR    = 2'd1,
    FLUSH_REDIRECT = 2'd2
  } flush_state_e;

  typedef struct packed {
    logic [PRED_IDX_W-1:0] index;
    logic                  real_jump;
    logic [ADDR_W-1:0]     target;
  } fb_entry_t;

  // Predictor table index taken from the instruction PC.
  function automatic logic [PRED_IDX_W-1:0] pred_index(input logic [ADDR_W-1:0] pc);
    return pc[PRED_IDX_LO +: PRED_IDX_W];
  endfunction

endpackage

// File: rtl/branch_feedback_fifo.sv
// Circular queue of resolved branch outcomes waiting to train the predictor.
module branch_feedback_fifo
  import branch_resolver_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  fb_entry_t push_data,
  input  logic      pop,
  output fb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Commit-side branch resolution: mispredict detection, predictor training
// queue and IF flush/redirect sequencing. BRANCH_STAT_EN adds commit counters.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  commit_valid,
  output logic                  commit_stall,
  input  logic                  commit_is_cond,
  input  logic [ADDR_W-1:0]     commit_pc,
  input  logic                  commit_real_jump,
  input  logic [ADDR_W-1:0]     commit_target_pc,
  input  logic [ADDR_W-1:0]     commit_pred_next_pc,
  output logic                  rob_enable_predictor,
  input  logic                  pred_update_ready,
  output logic                  real_jump_or_not,
  output logic [PRED_IDX_W-1:0] instr_pc,
  output logic [ADDR_W-1:0]     jump_to_pc_from_rob,
  output logic                  clear_all,
`ifdef BRANCH_STAT_EN
  output logic [STAT_W-1:0]     stat_branches,
  output logic [STAT_W-1:0]     stat_mispredicts,
`endif
  output logic                  redirect_valid,
  output logic [ADDR_W-1:0]     redirect_pc,
  input  logic                  if_redirect_ack
);

  flush_state_e      state;
  flush_state_e      state_d;
  logic              clear_all_d;
  logic              redirect_valid_d;
  logic [ADDR_W-1:0] redirect_pc_d;
  logic [ADDR_W-1:0] real_next;
  logic              accept;
  logic              mispredict;
  logic              push;
  logic              pop;
  logic              q_full;
  logic              q_empty;
  fb_entry_t         push_data;
  fb_entry_t         head;

  assign commit_stall = (state != FLUSH_IDLE) || q_full;
  assign accept       = rdy && commit_valid && !commit_stall;
  assign real_next    = commit_real_jump ? commit_target_pc : commit_pc + ADDR_W'(4);
  assign mispredict   = (real_next != commit_pred_next_pc);

  // Only conditional branches train the direction predictor.
  assign push      = accept && commit_is_cond;
  assign pop       = rdy && !q_empty && pred_update_ready;
  assign push_data = '{index: pred_index(commit_pc), real_jump: commit_real_jump,
                       target: commit_target_pc};

  branch_feedback_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .full     (q_full),
    .empty    (q_empty)
  );

  // Update port shows zeros while there is nothing to train.
  assign rob_enable_predictor = !q_empty;
  assign real_jump_or_not     = !q_empty && head.real_jump;
  assign instr_pc             = q_empty ? '0 : head.index;
  assign jump_to_pc_from_rob  = q_empty ? '0 : head.target;

  always_comb begin
    state_d       = state;
    redirect_pc_d = redirect_pc;
    if (rdy) begin
      unique case (state)
        FLUSH_IDLE: begin
          if (accept && mispredict) begin
            state_d       = FLUSH_CLEAR;
            redirect_pc_d = real_next;
          end
        end
        FLUSH_CLEAR:    state_d = FLUSH_REDIRECT;
        FLUSH_REDIRECT: if (if_redirect_ack) state_d = FLUSH_IDLE;
        default:        state_d = FLUSH_IDLE;
      endcase
    end
    clear_all_d      = (state_d == FLUSH_CLEAR);
    redirect_valid_d = (state_d == FLUSH_REDIRECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FLUSH_IDLE;
      clear_all      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state          <= state_d;
      clear_all      <= clear_all_d;
      redirect_valid <= redirect_valid_d;
      redirect_pc    <= redirect_pc_d;
    end
  end

`ifdef BRANCH_STAT_EN
  // Saturating commit statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (accept) begin
      if (stat_branches != '1) begin
        stat_branches <= stat_branches + STAT_W'(1);
      end
      if (mispredict && (stat_mispredicts != '1)) begin
        stat_mispredicts <= stat_mispredicts + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Commit-side counterpart of the instruction-fetch predictor. It takes retiring control-flow instructions from the ROB head and decides whether each one was mispredicted. Outcomes go into a small queue that trains the predictor. On a mispredict it runs a flush/redirect sequence toward IF and the rest of the core. It sits between the ROB commit port, the predictor's feedback port and IF's redirect port.

## Interface
- `DEPTH`, default 4: number of entries in the feedback queue; must be a power of 2.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `rdy` in 1: global enable; when low, all state holds.
- `commit_valid` in 1: the ROB head is a retiring jal/jalr/branch.
- `commit_stall` out 1: the ROB must hold its commit.
- `commit_is_cond` in 1: 1 for a conditional branch, 0 for jal/jalr.
- `commit_pc` in `ADDR`: PC of the instruction itself.
- `commit_real_jump` in 1: resolved taken flag.
- `commit_target_pc` in `ADDR`: resolved taken target.
- `commit_pred_next_pc` in `ADDR`: next PC that IF actually fetched after this instruction.
- `rob_enable_predictor` out 1: a predictor update is valid.
- `pred_update_ready` in 1: the predictor accepts an update this cycle.
- `real_jump_or_not` out 1: trained outcome.
- `instr_pc` out `PREDICTORINDEX`: predictor index, `commit_pc[PREDICTORINDEX]`.
- `jump_to_pc_from_rob` out `ADDR`: trained target.
- `clear_all` out 1: one-cycle flush pulse to IF/RS/LSB/ROB.
- `redirect_valid` out 1: a redirect PC is presented to IF.
- `redirect_pc` out `ADDR`: correct next PC.
- `if_redirect_ack` in 1: IF has taken the redirect.

## Operation
- **Accept rule:** a commit is accepted on a rising edge where `rdy`, `commit_valid` and `!commit_stall` are all high.
- **Resolution:** `real_next = commit_real_jump ? commit_target_pc : commit_pc + 4`, 32-bit wrap. `mispredict = (real_next != commit_pred_next_pc)`.
- **Training:** only accepted conditional branches (`commit_is_cond = 1`) push `{index, real_jump, target}` into the queue. Jal/jalr are checked for mispredict but never enqueued.
- **Queue:** circular, `DEPTH` entries, with a `log2(DEPTH)+1`-bit count.
  - The head drives the update outputs whenever the queue is non-empty.
  - An entry is popped on an edge where `rob_enable_predictor && pred_update_ready`.
  - Push and pop in the same cycle leave the count unchanged; the pointers wrap modulo `DEPTH`.
- **Flush FSM:** states IDLE, FLUSH, REDIRECT.
  - IDLE → FLUSH when an accepted commit mispredicts; `real_next` is latched into `redirect_pc`.
  - FLUSH lasts exactly one cycle with `clear_all = 1`, then → REDIRECT.
  - REDIRECT holds `redirect_valid = 1` until an edge with `if_redirect_ack`, then → IDLE.
- **Stall:** `commit_stall = (state != IDLE) || (count == DEPTH)`. This is purely combinational from registered state. The queue being full blocks a jal/jalr commit too.
- **Flush does not touch the queue.** Committed outcomes are architectural, so draining continues during FLUSH and REDIRECT.
- **Mispredict with a full queue:** cannot happen, because the commit is stalled until space frees.
- **`rdy` low:** freezes the FSM, the queue and every registered output. `clear_all` stays high if the freeze happens in FLUSH.

## Timing
- **Reset values:** `rob_enable_predictor = 0`, `real_jump_or_not = 0`, `instr_pc = 0`, `jump_to_pc_from_rob = 0`, `clear_all = 0`, `redirect_valid = 0`, `redirect_pc = 0`, `commit_stall = 0`; queue empty; FSM in IDLE.
- **Update latency:** a push into an empty queue at edge N makes `rob_enable_predictor = 1` in cycle N+1. With the predictor ready, that entry is popped at edge N+1.
- **Flush latency:** a mispredicted commit at edge N gives `clear_all = 1` in cycle N+1 and `redirect_valid = 1` from cycle N+2. `commit_stall = 1` from cycle N+1 until the cycle after the ack edge.
- **Reset mid-flush or mid-redirect:** returns to IDLE and drops all queue entries.
- **Back-to-back commits:** one accepted commit per cycle while not stalled.

## Configuration
- Macro `BRANCH_STAT_EN`.
- **Defined:** adds output ports `stat_branches` [31:0] and `stat_mispredicts` [31:0].
  - `stat_branches` counts accepted commits.
  - `stat_mispredicts` counts accepted commits that mispredict.
  - Both saturate at `32'hFFFFFFFF` and reset to 0.
- **Undefined:** the ports and counters are absent; all other behaviour is identical.

## Structure
- `ADDR` and `PREDICTORINDEX` come from `define.v`.
- Add `FLUSH_IDLE`/`FLUSH_CLEAR`/`FLUSH_REDIRECT` 2-bit state encodings to `define.v`.
- One sub-module: `branch_feedback_fifo`, a parameterised queue with push, pop, full and empty. The resolver owns the FSM, the compare logic and the stats.

## Test plan
- **Correct prediction:** commit a cond branch, pc `0x100`, real_jump 1, target `0x140`, pred_next `0x140` → no `clear_all`; next cycle `rob_enable_predictor = 1`, `instr_pc = 0x100[PREDICTORINDEX]`, `jump_to_pc_from_rob = 0x140`.
- **Mispredict:** cond branch pc `0x200`, real_jump 0, pred_next `0x240` → `clear_all` for 1 cycle; then `redirect_pc = 0x204` held while `if_redirect_ack` stays low for 3 cycles; FSM returns to IDLE on the ack edge.
- **Full queue:** hold `pred_update_ready = 0` and commit 5 branches → `commit_stall = 1` after 4 accepts; raise ready → drains in order, one entry per cycle, and the 5th commit is accepted.
- **Jalr target miss:** jalr with target `0x300` and pred_next `0x304` → flush; nothing enqueued.
- **Simultaneous push and pop:** push and pop in the same cycle at count 2 → count remains 2; pointer wrap is checked over 10 entries.
- **Reset during REDIRECT:** assert `rst` → all outputs at reset values next cycle. With `BRANCH_STAT_EN` defined, the counters read 0.
